fp_sum_driver: RTL and testbench
================================

Name: fp_sum_driver

Overview:
- Initiator side of the single-precision adder's strobe/ack protocol. Drives the adder's A/B operand ports and consumes its Z port.
- Accumulates a frame of float32 values, i.e. the softmax denominator. The frame is terminated by in_last, and the block emits the final sum with an element count.
- Sits between the exp stage (upstream, strobe/ack) and the divider stage (downstream, strobe/ack).

Parameters:
- CNT_W, 16, width of the element counter and sum_count.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_data  input  32  float32 element
- in_last  input  1  element is last of frame; sampled with in_data
- in_strb  input  1  upstream data valid
- in_ack  output  1  block ready to take an element
- add_a  output  32  accumulator operand to adder
- add_a_strb  output  1  add_a valid
- add_a_ack  input  1  adder ready for A
- add_b  output  32  element operand to adder
- add_b_strb  output  1  add_b valid
- add_b_ack  input  1  adder ready for B
- add_z  input  32  adder result
- add_z_strb  input  1  result valid
- add_z_ack  output  1  block ready for result
- sum_out  output  32  frame sum
- sum_count  output  CNT_W  elements in frame
- sum_strb  output  1  sum valid
- sum_ack  input  1  downstream ready

Behaviour:
- Protocol on every port:
  - A word transfers on the rising edge where strb and ack are both high.
  - Both strb and ack are registered. Each side deasserts its own signal on the transfer edge, so it reads low the next cycle. No double transfer.
  - Data is held stable while strb is high.
- Reset values: all strb/ack outputs 0, add_a/add_b/sum_out 0, sum_count 0, acc 32'h0000_0000, cnt 0, last_r 0, state GET_X.
- States and transitions:
  - GET_X: in_ack<=1. On in_strb&&in_ack: elem<=in_data, last_r<=in_last, cnt<=cnt+1 (saturates at all-ones), in_ack<=0 -> PUT_A.
  - PUT_A: add_a=acc, add_a_strb<=1. On transfer: strb<=0 -> PUT_B.
  - PUT_B: add_b=elem, add_b_strb<=1. On transfer: strb<=0 -> GET_Z.
  - GET_Z: add_z_ack<=1. On add_z_strb&&add_z_ack: acc<=add_z, ack<=0. Then -> PUT_SUM if last_r, else -> GET_X.
  - PUT_SUM: sum_out=acc, sum_count=cnt, sum_strb<=1. On transfer: strb<=0, acc<=0, cnt<=0 -> GET_X.
- A is always presented before B, matching the adder's fixed get_a/get_b order.
- No arithmetic in this block. acc is only loaded from add_z or cleared.
- Latency: minimum 6 cycles per element with a zero-wait responder (2 per port). Plus 2 cycles for sum emission.
- Backpressure: any ack held low stalls the block indefinitely in the current state. Outputs hold and no upstream element is accepted.
- in_ack is never high outside GET_X. Elements never overlap an in-flight add.
- Frames of any length >=1. A frame never spans a reset.
- Reset mid-operation: all strb/ack drop low on the next edge, and the partial frame is discarded. The adder shares rst, so both ends restart together.
- NaN/Inf pass through unchanged; they are the adder's responsibility.

Optional Feature:
- FP_SUM_BYPASS_FIRST_EN defined:
  - The first element of a frame (cnt==0 at acceptance) loads acc directly and skips PUT_A/PUT_B/GET_Z.
  - Saves one adder round trip per frame.
  - Preserves the sign of a lone -0.0.
- Undefined: acc starts at +0.0 and every element goes through the adder. A single -0.0 yields +0.0.

Decomposition:
- Package fp_sum_pkg holds:
  - state encoding localparams (GET_X=0 .. PUT_SUM=4)
  - FP_POS_ZERO = 32'h0000_0000
  - port-protocol comments
- One natural sub-module, strb_ack_tx: a one-word registered strobe source, load/hold/clear on transfer. It is instantiated for the A, B and sum ports.

Test Plan:
- 0x3F800000, 0x40000000, 0x40400000 (last) with a real adder -> sum_out 0x40C00000, sum_count 3, single sum_strb pulse.
- Single element 0x40490FDB with in_last -> sum_out 0x40490FDB, count 1.
- sum_ack held low 10 cycles after sum_strb -> sum_out/sum_count stable, in_ack stays 0. Next frame 2.0+2.0 -> 0x40800000, count 2.
- Stub responder with add_a_ack delayed 5 cycles and add_z_strb delayed 8 cycles -> add_a stable and add_a_strb high throughout. Exactly one transfer per port per element, checked by a protocol assertion.
- rst asserted in PUT_B -> all strb/ack low next cycle. Following frame 1.0+1.0 -> 0x40000000, count 2 (no stale accumulation).
- Single element 0x80000000 -> 0x80000000 with FP_SUM_BYPASS_FIRST_EN, 0x00000000 without.

Source files
------------

// File: rtl/fp_sum_pkg.sv
// Shared state encoding and constants for the float32 frame-sum driver.
// Ports use strobe/ack: a word moves on a rising edge with strb && ack both high.
// Each side registers its own signal and drops it on that edge. Data holds while strb is high.
package fp_sum_pkg;

    localparam int unsigned FP_W = 32;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        GET_X   = 3'd0,
        PUT_A   = 3'd1,
        PUT_B   = 3'd2,
        GET_Z   = 3'd3,
        PUT_SUM = 3'd4
    } state_t;

endpackage

// File: rtl/strb_ack_tx.sv
// One-word registered strobe source: load raises strb with a new word,
// the word holds until the transfer edge, where strb drops.
module strb_ack_tx #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ack,
    output logic         strb,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            strb <= 1'b0;
            data <= '0;
        end else if (load) begin
            strb <= 1'b1;
            data <= load_data;
        end else if (strb && ack) begin
            strb <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_sum_driver.sv
// Accumulates a frame of float32 elements through an external strobe/ack adder
// and emits the frame sum with its element count. FP_SUM_BYPASS_FIRST_EN loads the first element directly.
module fp_sum_driver
    import fp_sum_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_last,
    input  logic             in_strb,
    output logic             in_ack,
    output logic [FP_W-1:0]  add_a,
    output logic             add_a_strb,
    input  logic             add_a_ack,
    output logic [FP_W-1:0]  add_b,
    output logic             add_b_strb,
    input  logic             add_b_ack,
    input  logic [FP_W-1:0]  add_z,
    input  logic             add_z_strb,
    output logic             add_z_ack,
    output logic [FP_W-1:0]  sum_out,
    output logic [CNT_W-1:0] sum_count,
    output logic             sum_strb,
    input  logic             sum_ack
);

    localparam int unsigned SUM_W = FP_W + CNT_W;

    state_t            state, state_d;
    logic [FP_W-1:0]   acc, acc_d;
    logic [FP_W-1:0]   elem, elem_d;
    logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
    logic              last_r, last_d;
    logic              in_ack_d, add_z_ack_d;
    logic              load_a, load_b, load_sum;
    logic              in_fire, a_fire, b_fire, z_fire, sum_fire;
    logic [SUM_W-1:0]  sum_word;

    assign in_fire  = in_strb && in_ack;
    assign a_fire   = add_a_strb && add_a_ack;
    assign b_fire   = add_b_strb && add_b_ack;
    assign z_fire   = add_z_strb && add_z_ack;
    assign sum_fire = sum_strb && sum_ack;

    // Next state, datapath updates and the one-cycle load pulses for the output ports
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        elem_d      = elem;
        cnt_d       = cnt;
        last_d      = last_r;
        cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
        case (state)
            GET_X: begin
                if (in_fire) begin
                    elem_d = in_data;
                    last_d = in_last;
                    cnt_d  = cnt_inc;
`ifdef FP_SUM_BYPASS_FIRST_EN
                    if (cnt == '0) begin
                        acc_d   = in_data;
                        state_d = in_last ? PUT_SUM : GET_X;
                    end else begin
                        state_d = PUT_A;
                    end
`else
                    state_d = PUT_A;
`endif
                end
            end
            PUT_A:   if (a_fire) state_d = PUT_B;
            PUT_B:   if (b_fire) state_d = GET_Z;
            GET_Z: begin
                if (z_fire) begin
                    acc_d   = add_z;
                    state_d = last_r ? PUT_SUM : GET_X;
                end
            end
            PUT_SUM: begin
                if (sum_fire) begin
                    acc_d   = FP_POS_ZERO;
                    cnt_d   = '0;
                    state_d = GET_X;
                end
            end
            default: state_d = GET_X;
        endcase
        load_a      = (state_d == PUT_A)   && (state != PUT_A);
        load_b      = (state_d == PUT_B)   && (state != PUT_B);
        load_sum    = (state_d == PUT_SUM) && (state != PUT_SUM);
        // An ack stays low for a cycle after its transfer, even when the state is re-entered
        in_ack_d    = (state_d == GET_X) && !in_fire;
        add_z_ack_d = (state_d == GET_Z) && !z_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= GET_X;
            acc       <= FP_POS_ZERO;
            elem      <= FP_POS_ZERO;
            cnt       <= '0;
            last_r    <= 1'b0;
            in_ack    <= 1'b0;
            add_z_ack <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            elem      <= elem_d;
            cnt       <= cnt_d;
            last_r    <= last_d;
            in_ack    <= in_ack_d;
            add_z_ack <= add_z_ack_d;
        end
    end

    strb_ack_tx #(.W(FP_W)) u_tx_a (
        .clk       (clk),
        .rst       (rst),
        .load      (load_a),
        .load_data (acc_d),
        .ack       (add_a_ack),
        .strb      (add_a_strb),
        .data      (add_a)
    );

    strb_ack_tx #(.W(FP_W)) u_tx_b (
        .clk       (clk),
        .rst       (rst),
        .load      (load_b),
        .load_data (elem),
        .ack       (add_b_ack),
        .strb      (add_b_strb),
        .data      (add_b)
    );

    strb_ack_tx #(.W(SUM_W)) u_tx_sum (
        .clk       (clk),
        .rst       (rst),
        .load      (load_sum),
        .load_data ({acc_d, cnt_d}),
        .ack       (sum_ack),
        .strb      (sum_strb),
        .data      (sum_word)
    );

    assign sum_out   = sum_word[SUM_W-1:CNT_W];
    assign sum_count = sum_word[CNT_W-1:0];

endmodule

// File: tb/tb_fp_sum_driver.sv
// Bench for fp_sum_driver: float32 adder stub with programmable delays, frame-sum reference model,
// and a per-cycle protocol monitor. Honours FP_SUM_BYPASS_FIRST_EN.
module tb_fp_sum_driver;

    localparam int unsigned CNT_W = 16;
    localparam int TMO = 300;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      in_data;
    logic             in_last;
    logic             in_strb;
    logic             in_ack;
    logic [31:0]      add_a;
    logic             add_a_strb;
    logic             add_a_ack;
    logic [31:0]      add_b;
    logic             add_b_strb;
    logic             add_b_ack;
    logic [31:0]      add_z;
    logic             add_z_strb;
    logic             add_z_ack;
    logic [31:0]      sum_out;
    logic [CNT_W-1:0] sum_count;
    logic             sum_strb;
    logic             sum_ack;

    int checks = 0;
    int errors = 0;
    int a_dly = 0;
    int b_dly = 0;
    int z_dly = 0;

    fp_sum_driver #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_strb    (in_strb),
        .in_ack     (in_ack),
        .add_a      (add_a),
        .add_a_strb (add_a_strb),
        .add_a_ack  (add_a_ack),
        .add_b      (add_b),
        .add_b_strb (add_b_strb),
        .add_b_ack  (add_b_ack),
        .add_z      (add_z),
        .add_z_strb (add_z_strb),
        .add_z_ack  (add_z_ack),
        .sum_out    (sum_out),
        .sum_count  (sum_count),
        .sum_strb   (sum_strb),
        .sum_ack    (sum_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic real f32_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0)       d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
        else                        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]);
        if (e == 0)    return {d[63], 31'd0};
        if (e == 2047) return {d[63], 8'hFF, d[51:29]};
        return {d[63], 8'(e - 896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return real_to_f32(f32_to_real(a) + f32_to_real(b));
    endfunction

    function automatic logic [31:0] itof(input int v);
        return real_to_f32($itor(v));
    endfunction

    // Adder stub: takes A, then B, then returns A+B on Z, each with its own delay
    initial begin : responder
        int ph, wc;
        logic pa, pb, pz;
        logic [31:0] ra, rb, cap_a, cap_b;
        ph = 0; wc = 0; pa = 1'b0; pb = 1'b0; pz = 1'b0;
        ra = '0; rb = '0; cap_a = '0; cap_b = '0;
        add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_strb = 1'b0; add_z = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                ph = 0; wc = 0; pa = 1'b0; pb = 1'b0; pz = 1'b0;
                add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_strb = 1'b0;
            end else begin
                case (ph)
                    0: if (pa) begin ra = cap_a; add_a_ack = 1'b0; ph = 1; wc = 0; end
                       else if (add_a_strb) begin if (wc >= a_dly) add_a_ack = 1'b1; else wc++; end
                    1: if (pb) begin rb = cap_b; add_b_ack = 1'b0; ph = 2; wc = 0; end
                       else if (add_b_strb) begin if (wc >= b_dly) add_b_ack = 1'b1; else wc++; end
                    2: if (pz) begin add_z_strb = 1'b0; ph = 0; wc = 0; end
                       else if (wc >= z_dly) begin add_z = fadd(ra, rb); add_z_strb = 1'b1; end
                       else wc++;
                    default: ph = 0;
                endcase
                pa = add_a_strb && add_a_ack; cap_a = add_a;
                pb = add_b_strb && add_b_ack; cap_b = add_b;
                pz = add_z_strb && add_z_ack;
            end
        end
    end

    // Monitor: frame model, sum scoreboard, hold-stability and exclusivity checks
    initial begin : monitor
        logic [31:0] frame[$];
        logic [31:0] exp_sum[$];
        int exp_cnt[$];
        int exp_nadd[$];
        logic pin, pa, pb, pz, ps, clast, ha, hb, hs;
        logic [31:0] cin, pva, pvb, acc_m;
        logic [47:0] cs, pvs;
        int na, nb, nz, st;
        pin = 0; pa = 0; pb = 0; pz = 0; ps = 0; clast = 0; ha = 0; hb = 0; hs = 0;
        cin = '0; pva = '0; pvb = '0; cs = '0; pvs = '0; acc_m = '0;
        na = 0; nb = 0; nz = 0; st = 0;
        forever begin
            @(negedge clk);
            if (pin) begin
                frame.push_back(cin);
                if (clast) begin
`ifdef FP_SUM_BYPASS_FIRST_EN
                    acc_m = frame[0]; st = 1;
`else
                    acc_m = 32'h0000_0000; st = 0;
`endif
                    for (int i = st; i < frame.size(); i++) acc_m = fadd(acc_m, frame[i]);
                    exp_sum.push_back(acc_m);
                    exp_cnt.push_back(frame.size());
                    exp_nadd.push_back(frame.size() - st);
                    frame.delete();
                end
            end
            if (pa) na++;
            if (pb) nb++;
            if (pz) nz++;
            if (ps) begin
                if (exp_sum.size() == 0) begin
                    check("sum_unexpected", 64'(cs), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("model_sum", 64'(cs[47:16]), 64'(exp_sum.pop_front()));
                    check("model_count", 64'(cs[15:0]), 64'(exp_cnt.pop_front()));
                    st = exp_nadd.pop_front();
                    check("xfers_a", 64'(na), 64'(st));
                    check("xfers_b", 64'(nb), 64'(st));
                    check("xfers_z", 64'(nz), 64'(st));
                end
                na = 0; nb = 0; nz = 0;
            end
            if (rst) begin
                frame.delete(); exp_sum.delete(); exp_cnt.delete(); exp_nadd.delete();
                pin = 0; pa = 0; pb = 0; pz = 0; ps = 0; ha = 0; hb = 0; hs = 0;
                na = 0; nb = 0; nz = 0;
                continue;
            end
            if (ha) check("hold_a", {31'd0, add_a_strb, add_a}, {31'd0, 1'b1, pva});
            if (hb) check("hold_b", {31'd0, add_b_strb, add_b}, {31'd0, 1'b1, pvb});
            if (hs) check("hold_sum", {15'd0, sum_strb, sum_out, sum_count}, {15'd0, 1'b1, pvs});
            check("in_ack_excl", 64'(in_ack && (add_a_strb || add_b_strb || add_z_ack || sum_strb)), 64'd0);
            pin = in_strb && in_ack; cin = in_data; clast = in_last;
            pa = add_a_strb && add_a_ack;
            pb = add_b_strb && add_b_ack;
            pz = add_z_strb && add_z_ack;
            ps = sum_strb && sum_ack; cs = {sum_out, sum_count};
            ha = add_a_strb && !add_a_ack; pva = add_a;
            hb = add_b_strb && !add_b_ack; pvb = add_b;
            hs = sum_strb && !sum_ack;     pvs = {sum_out, sum_count};
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input int gap);
        logic fire;
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        in_data = d; in_last = l; in_strb = 1'b1;
        t = 0;
        forever begin
            fire = in_ack;
            @(posedge clk); #1;
            if (fire) break;
            if (++t > TMO) begin check("send_timeout", 64'd0, 64'd1); break; end
        end
        in_strb = 1'b0;
    endtask

    task automatic get_sum(input logic lit, input logic [31:0] es, input int ec, input int hold);
        logic fire;
        int t;
        t = 0;
        while (!sum_strb) begin
            @(posedge clk); #1;
            if (++t > TMO) begin check("sum_timeout", 64'd0, 64'd1); return; end
        end
        if (lit) begin
            check("sum_out", 64'(sum_out), 64'(es));
            check("sum_count", 64'(sum_count), 64'(ec));
        end
        repeat (hold) begin
            check("in_ack_while_sum", 64'(in_ack), 64'd0);
            @(posedge clk); #1;
        end
        if (lit && hold > 0) begin
            check("sum_out_held", {31'd0, sum_strb, sum_out}, {31'd0, 1'b1, es});
            check("sum_count_held", 64'(sum_count), 64'(ec));
        end
        sum_ack = 1'b1;
        t = 0;
        forever begin
            fire = sum_strb;
            @(posedge clk); #1;
            if (fire) break;
            if (++t > TMO) begin check("sum_ack_timeout", 64'd0, 64'd1); break; end
        end
        sum_ack = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n, t;
        logic [31:0] neg_zero_exp;
        rst = 1'b1; in_data = '0; in_last = 1'b0; in_strb = 1'b0; sum_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ack", 64'(in_ack), 64'd0);
        check("rst_a_strb", 64'(add_a_strb), 64'd0);
        check("rst_b_strb", 64'(add_b_strb), 64'd0);
        check("rst_z_ack", 64'(add_z_ack), 64'd0);
        check("rst_sum_strb", 64'(sum_strb), 64'd0);
        check("rst_data", {add_a, add_b}, 64'd0);
        check("rst_sum", {sum_out, 16'd0, sum_count}, 64'd0);
        rst = 1'b0;

        check("model_pin_1p2", 64'(fadd(32'h3F80_0000, 32'h4000_0000)), 64'h4040_0000);
        check("model_pin_3p3", 64'(fadd(32'h4040_0000, 32'h4040_0000)), 64'h40C0_0000);

        send(32'h3F80_0000, 1'b0, 0);
        send(32'h4000_0000, 1'b0, 0);
        send(32'h4040_0000, 1'b1, 0);
        get_sum(1'b1, 32'h40C0_0000, 3, 0);

        send(32'h4049_0FDB, 1'b1, 1);
        get_sum(1'b1, 32'h4049_0FDB, 1, 0);

        send(32'h3F80_0000, 1'b0, 0);
        send(32'h4000_0000, 1'b1, 0);
        get_sum(1'b1, 32'h4040_0000, 2, 10);
        send(32'h4000_0000, 1'b0, 0);
        send(32'h4000_0000, 1'b1, 0);
        get_sum(1'b1, 32'h4080_0000, 2, 0);

        a_dly = 5; z_dly = 8;
        send(32'h3F80_0000, 1'b0, 0);
        send(32'h4000_0000, 1'b1, 0);
        get_sum(1'b1, 32'h4040_0000, 2, 0);
        a_dly = 0; z_dly = 0;

        // Reset while B is being offered: everything must drop and the partial frame vanish
        b_dly = 50;
        send(32'h4040_0000, 1'b0, 0);
        t = 0;
        while (!add_b_strb && t < TMO) begin @(posedge clk); #1; t++; end
        check("reach_put_b", 64'(add_b_strb), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ack", 64'(in_ack), 64'd0);
        check("midrst_a_strb", 64'(add_a_strb), 64'd0);
        check("midrst_b_strb", 64'(add_b_strb), 64'd0);
        check("midrst_z_ack", 64'(add_z_ack), 64'd0);
        check("midrst_sum_strb", 64'(sum_strb), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; b_dly = 0;
        send(32'h3F80_0000, 1'b0, 0);
        send(32'h3F80_0000, 1'b1, 0);
        get_sum(1'b1, 32'h4000_0000, 2, 0);

`ifdef FP_SUM_BYPASS_FIRST_EN
        neg_zero_exp = 32'h8000_0000;
`else
        neg_zero_exp = 32'h0000_0000;
`endif
        send(32'h8000_0000, 1'b1, 0);
        get_sum(1'b1, neg_zero_exp, 1, 0);

        for (int f = 0; f < 25; f++) begin
            a_dly = int'($urandom_range(0, 3));
            b_dly = int'($urandom_range(0, 3));
            z_dly = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++)
                send(itof(int'($urandom_range(0, 200)) - 100), i == n - 1, int'($urandom_range(0, 2)));
            get_sum(1'b0, 32'd0, 0, int'($urandom_range(0, 3)));
        end

        repeat (5) begin @(posedge clk); #1; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
